// File: rtl/decode_stage_pkg.sv
// Shared decode types: instruction field positions, class/funcode enums and the
// decoded-control struct produced from one 32-bit instruction word.
package decode_pkg;

  localparam int FT_HI      = 31;
  localparam int FT_LO      = 30;
  localparam int FC_HI      = 29;
  localparam int FC_LO      = 28;
  localparam int RD_HI      = 27;
  localparam int RD_LO      = 24;
  localparam int RS_HI      = 23;
  localparam int RS_LO      = 20;
  localparam int RX_HI      = 19;
  localparam int RX_LO      = 16;
  localparam int IMM19_HI   = 19;
  localparam int IMM19_LO   = 1;
  localparam int IMM28_HI   = 27;
  localparam int IMM28_LO   = 0;
  localparam int IMM4_HI    = 23;
  localparam int IMM4_LO    = 20;
  localparam int IMMSEL_BIT = 0;

  typedef enum logic [1:0] {FT_REG = 2'b00, FT_MEM = 2'b01, FT_BR = 2'b10, FT_KERN = 2'b11} funtype_e;
  typedef enum logic [1:0] {FC_ADD = 2'b00, FC_SUB = 2'b01, FC_MOV = 2'b10, FC_CMP = 2'b11} reg_fc_e;
  typedef enum logic [1:0] {FC_LOAD = 2'b00, FC_STORE = 2'b01} mem_fc_e;
  typedef enum logic [1:0] {FC_KWB = 2'b00, FC_CACHEWR = 2'b10} kern_fc_e;
  typedef enum logic [1:0] {IMM_4 = 2'd0, IMM_19 = 2'd1, IMM_28 = 2'd2} imm_sel_e;

  typedef struct packed {
    logic       wb;
    logic       memrd;
    logic       memwr;
    logic       branch;
    logic       cachewr;
    logic       zero_a;   // operand A forced to 0, so source A is not read
    logic       use_imm;  // operand B from immediate, so source B is not read
    imm_sel_e   imm_sel;
    logic [3:0] a_addr;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode(input logic [31:0] instr);
    dec_ctrl_t  d;
    funtype_e   ft;
    logic [1:0] fc;
    ft        = funtype_e'(instr[FT_HI:FT_LO]);
    fc        = instr[FC_HI:FC_LO];
    d         = '0;
    d.memrd   = (ft == FT_MEM) && (fc == FC_LOAD);
    d.memwr   = (ft == FT_MEM) && (fc == FC_STORE);
    d.branch  = (ft == FT_BR);
    d.cachewr = (ft == FT_KERN) && (fc == FC_CACHEWR);
    d.wb      = ((ft == FT_REG) && (fc != FC_CMP)) || d.memrd || d.branch ||
                ((ft == FT_KERN) && (fc == FC_KWB));
    d.zero_a  = ((ft == FT_REG) && (fc == FC_MOV)) || (ft == FT_KERN);
    d.use_imm = instr[IMMSEL_BIT] || d.cachewr;
    d.a_addr  = ((ft == FT_REG) && (fc == FC_CMP)) ? instr[RD_HI:RD_LO] : instr[RS_HI:RS_LO];
    if (d.cachewr)          d.imm_sel = IMM_4;
    else if (ft == FT_REG)  d.imm_sel = IMM_19;
    else                    d.imm_sel = IMM_28;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_imm_extend.sv
// Immediate select (imm4 / imm19 / imm28) and zero/sign extension to DATA_W.
module imm_extend
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SEXT_IMM = 0
) (
  input  logic [27:0]       fields,
  input  imm_sel_e          imm_sel,
  output logic [DATA_W-1:0] imm
);

  localparam bit SX = (SEXT_IMM != 0);

  logic [3:0]  i4;
  logic [18:0] i19;
  logic [27:0] i28;

  assign i4  = fields[IMM4_HI:IMM4_LO];
  assign i19 = fields[IMM19_HI:IMM19_LO];
  assign i28 = fields[IMM28_HI:IMM28_LO];

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_4:   imm = {{(DATA_W-4){SX && i4[3]}}, i4};
      IMM_19:  imm = {{(DATA_W-19){SX && i19[18]}}, i19};
      IMM_28:  imm = {{(DATA_W-28){SX && i28[27]}}, i28};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-cycle instr -> ex register with ready/valid backpressure.
// Define DECODE_INTERLOCK_EN for the load-use interlock (RUN/BUBBLE FSM, stall_cnt).
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SEXT_IMM = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  output logic [3:0]        rf_a_addr,
  output logic [3:0]        rf_b_addr,
  input  logic [DATA_W-1:0] rf_a_data,
  input  logic [DATA_W-1:0] rf_b_data,
  input  logic [DATA_W-1:0] rf_d_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [1:0]        ex_funtype,
  output logic [1:0]        ex_funcode,
  output logic [3:0]        ex_rd,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [DATA_W-1:0] ex_stdata,
  output logic [DATA_W-1:0] ex_pc,
  output logic              ex_wb,
  output logic              ex_memrd,
  output logic              ex_memwr,
  output logic              ex_branch,
  output logic              ex_cachewr,
  output logic [CNT_W-1:0]  stall_cnt
);

  dec_ctrl_t         dc;
  logic [DATA_W-1:0] imm;
  logic              load_en, hazard, accept, rst_hold;

  assign dc        = decode(instr);
  assign rf_a_addr = dc.a_addr;
  assign rf_b_addr = instr[RX_HI:RX_LO];

  imm_extend #(.DATA_W(DATA_W), .SEXT_IMM(SEXT_IMM)) u_imm (
    .fields  (instr[27:0]),
    .imm_sel (dc.imm_sel),
    .imm     (imm)
  );

  // Blocks acceptance for the first edge after reset release so an instr
  // presented across the release is dropped.
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_hold <= 1'b1;
    else     rst_hold <= 1'b0;

  assign load_en  = !ex_valid || ex_ready;
  assign in_ready = load_en && !hazard && !flush && !rst_hold;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_funtype <= '0;
      ex_funcode <= '0;
      ex_rd      <= '0;
      ex_opa     <= '0;
      ex_opb     <= '0;
      ex_stdata  <= '0;
      ex_pc      <= '0;
      ex_wb      <= 1'b0;
      ex_memrd   <= 1'b0;
      ex_memwr   <= 1'b0;
      ex_branch  <= 1'b0;
      ex_cachewr <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load_en) begin
      ex_valid <= accept;
      if (accept) begin
        ex_funtype <= instr[FT_HI:FT_LO];
        ex_funcode <= instr[FC_HI:FC_LO];
        ex_rd      <= instr[RD_HI:RD_LO];
        ex_opa     <= dc.zero_a ? '0 : rf_a_data;
        ex_opb     <= dc.use_imm ? imm : rf_b_data;
        ex_stdata  <= rf_d_data;
        ex_pc      <= pc_in;
        ex_wb      <= dc.wb;
        ex_memrd   <= dc.memrd;
        ex_memwr   <= dc.memwr;
        ex_branch  <= dc.branch;
        ex_cachewr <= dc.cachewr;
      end
    end
  end

`ifdef DECODE_INTERLOCK_EN
  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_e;

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             a_hit, b_hit;

  // Load-use: the load in ex cannot forward, so a dependent instr waits one bubble.
  assign a_hit  = !dc.zero_a && (ex_rd == dc.a_addr);
  assign b_hit  = !dc.use_imm && (ex_rd == rf_b_addr);
  assign hazard = ex_valid && ex_memrd && in_valid && (a_hit || b_hit);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = RUN;
    end else begin
      case (state)
        RUN: if (hazard && load_en) begin
          state_nx = BUBBLE;
          if (cnt != '1) cnt_nx = cnt + CNT_W'(1);
        end
        BUBBLE: if (load_en) state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign stall_cnt = cnt;
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;
`endif

endmodule
